rgb_sbit_decode: RTL and testbench

Front-end decoder of the RGB-to-RGBW path. It samples the raw WS2812-style serial input line and classifies each high pulse as a 0 or 1 bit by its width. It also detects the 50 µs low "stream reset" gap. Results go out as single-clock strobes on the `in_strobe` / `in_sbit_value` / `in_stream_reset` inputs of `rgb_sbit2wrd`.

---
 rtl/rgb_sbit_decode.sv | 143 ++++++++++++++
 tb/tb_rgb_sbit_decode.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_sbit_decode.sv
// WS2812-style serial front end: classifies each high pulse on din as a 0/1 bit
// by its width, and flags the long low gap that marks a stream reset.
module rgb_sbit_decode #(
  parameter int SAMPLE_TIME_CLKS  = 57,
  parameter int MIN_HIGH_CLKS     = 10,
  parameter int MAX_HIGH_CLKS     = 144,
  parameter int STREAM_RESET_CLKS = 4800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       out_strobe,
  output logic       out_sbit_value,
  output logic       out_stream_reset,
  output logic       err_stuck,
  output logic [7:0] glitch_cnt
);

  localparam int CNT_W = $clog2(STREAM_RESET_CLKS + 1);

  localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(SAMPLE_TIME_CLKS);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH_CLKS);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HIGH_CLKS);
  localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(STREAM_RESET_CLKS);

  localparam logic [1:0] S_LOW  = 2'd0;
  localparam logic [1:0] S_BIT  = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  logic             sync1_q, sync2_q, dinD_q;
  logic             dinS, riseEdge;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cntInc;
  logic             rstSeen_q, rstSeen_d;
  logic             strobe_q, strobe_d;
  logic             value_q, value_d;
  logic             streamRst_q, streamRst_d;
  logic             errStuck_q, errStuck_d;
  logic [7:0]       glitchCnt_q, glitchCnt_d;

  // Two flops tame metastability; the third gives the previous level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dinD_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      dinD_q  <= sync2_q;
    end
  end

  assign dinS     = sync2_q;
  assign riseEdge = dinS & ~dinD_q;
  assign cntInc   = (cnt_q == RESET_C) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rstSeen_d   = rstSeen_q;
    strobe_d    = 1'b0;
    value_d     = 1'b0;
    streamRst_d = 1'b0;
    errStuck_d  = errStuck_q;
    glitchCnt_d = glitchCnt_q;

    case (state_q)
      S_LOW: begin
        if ((cnt_q == RESET_C) && !rstSeen_q) begin
          strobe_d    = 1'b1;
          streamRst_d = 1'b1;
          rstSeen_d   = 1'b1;
        end
        if (riseEdge) begin
          state_d   = S_BIT;
          cnt_d     = CNT_W'(1);
          rstSeen_d = 1'b0;
        end else begin
          cnt_d = cntInc;
        end
      end

      // Only the line level at the two check points matters inside a bit.
      S_BIT: begin
        cnt_d = cntInc;
        if ((cnt_q == MIN_C) && !dinS) begin
          state_d = S_LOW;
          cnt_d   = '0;
          if (glitchCnt_q != 8'hFF) glitchCnt_d = glitchCnt_q + 8'd1;
        end else if (cnt_q == SAMPLE_C) begin
          strobe_d = 1'b1;
          value_d  = dinS;
          state_d  = S_TAIL;
        end
      end

      S_TAIL: begin
        if (!dinS) begin
          state_d = S_LOW;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cntInc;
          if (cnt_q == MAX_C) errStuck_d = 1'b1;
        end
      end

      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOW;
      cnt_q       <= '0;
      rstSeen_q   <= 1'b0;
      strobe_q    <= 1'b0;
      value_q     <= 1'b0;
      streamRst_q <= 1'b0;
      errStuck_q  <= 1'b0;
      glitchCnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rstSeen_q   <= rstSeen_d;
      strobe_q    <= strobe_d;
      value_q     <= value_d;
      streamRst_q <= streamRst_d;
      errStuck_q  <= errStuck_d;
      glitchCnt_q <= glitchCnt_d;
    end
  end

  assign out_strobe       = strobe_q;
  assign out_sbit_value   = value_q;
  assign out_stream_reset = streamRst_q;
  assign err_stuck        = errStuck_q;
  assign glitch_cnt       = glitchCnt_q;

endmodule

// File: tb/tb_rgb_sbit_decode.sv
// Scoreboard bench for rgb_sbit_decode: expected strobes are queued with their
// exact cycle when a pulse is driven, and matched as the decoder emits them.
module tb_rgb_sbit_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       out_strobe;
  logic       out_sbit_value;
  logic       out_stream_reset;
  logic       err_stuck;
  logic [7:0] glitch_cnt;

  int unsigned cyc = 0;
  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    int unsigned cyc;
    logic        isReset;
    logic        value;
  } exp_t;

  exp_t sbQ[$];

  rgb_sbit_decode dut (
    .clk              (clk),
    .rst              (rst),
    .din              (din),
    .out_strobe       (out_strobe),
    .out_sbit_value   (out_sbit_value),
    .out_stream_reset (out_stream_reset),
    .err_stuck        (err_stuck),
    .glitch_cnt       (glitch_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Samples the strobe outputs at the falling edge, then returns just after the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (out_strobe === 1'b1) begin
      assertCount++;
      if (sbQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpected_strobe: strobe at cycle %0d (stream_reset=%0b value=%0b), required none",
                 cyc, out_stream_reset, out_sbit_value);
      end else begin
        e = sbQ.pop_front();
        if (cyc !== e.cyc || out_stream_reset !== e.isReset || out_sbit_value !== e.value) begin
          failCount++;
          $display("[TB] FAIL strobe_match: got cycle %0d stream_reset=%0b value=%0b, required cycle %0d stream_reset=%0b value=%0b",
                   cyc, out_stream_reset, out_sbit_value, e.cyc, e.isReset, e.value);
        end
      end
    end else if (sbQ.size() != 0 && cyc > sbQ[0].cyc) begin
      e = sbQ.pop_front();
      assertCount++;
      failCount++;
      $display("[TB] FAIL missed_strobe: no strobe by cycle %0d, required at cycle %0d (stream_reset=%0b value=%0b)",
               cyc, e.cyc, e.isReset, e.value);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendPulse(input int highClks, input int lowClks, input bit doPush, input logic val);
    exp_t e;
    int unsigned n;
    n = cyc;
    din = 1'b1;
    if (doPush) begin
      e = '{n + 60, 1'b0, val};
      sbQ.push_back(e);
    end
    repeat (highClks) step();
    din = 1'b0;
    repeat (lowClks) step();
  endtask

  task automatic test_reset();
    exp_t e;
    int unsigned r;
    rst = 1'b0;
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    assertCount++;
    if ({out_strobe, out_sbit_value, out_stream_reset, err_stuck} !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got %b, required 0000",
               {out_strobe, out_sbit_value, out_stream_reset, err_stuck});
    end
    assertCount++;
    if (glitch_cnt !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL reset_glitch_cnt: got %0d, required 0", glitch_cnt);
    end
    rst = 1'b1;
    r = cyc;
    e = '{r + 4801, 1'b1, 1'b0};
    sbQ.push_back(e);
    repeat (4850) step();
  endtask

  task automatic test_bit0();
    sendPulse(38, 82, 1'b1, 1'b0);
  endtask

  task automatic test_bit_seq();
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) sendPulse(77, 43, 1'b1, 1'b1);
      else            sendPulse(38, 82, 1'b1, 1'b0);
    end
    assertCount++;
    if (glitch_cnt !== 8'd0 || err_stuck !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL seq_errors: got glitch_cnt=%0d err_stuck=%0b, required 0/0", glitch_cnt, err_stuck);
    end
  endtask

  task automatic test_stream_reset();
    exp_t e;
    int unsigned n;
    n = cyc;
    din = 1'b1;
    e = '{n + 60, 1'b0, 1'b1};
    sbQ.push_back(e);
    repeat (77) step();
    din = 1'b0;
    e = '{n + 77 + 4803, 1'b1, 1'b0};
    sbQ.push_back(e);
    repeat (10000) step();
  endtask

  task automatic test_glitch();
    sendPulse(5, 100, 1'b0, 1'b0);
    assertCount++;
    if (glitch_cnt !== 8'd1) begin
      failCount++;
      $display("[TB] FAIL glitch_one: got %0d, required 1", glitch_cnt);
    end
    for (int i = 1; i < 300; i++) begin
      sendPulse(5, 100, 1'b0, 1'b0);
      if (i == 253) begin
        assertCount++;
        if (glitch_cnt !== 8'd254) begin
          failCount++;
          $display("[TB] FAIL glitch_254: got %0d, required 254", glitch_cnt);
        end
      end
    end
    assertCount++;
    if (glitch_cnt !== 8'd255) begin
      failCount++;
      $display("[TB] FAIL glitch_saturate: got %0d, required 255", glitch_cnt);
    end
  endtask

  task automatic test_stuck();
    exp_t e;
    int unsigned n;
    n = cyc;
    din = 1'b1;
    e = '{n + 60, 1'b0, 1'b1};
    sbQ.push_back(e);
    for (int i = 0; i < 300; i++) begin
      step();
      if (cyc == n + 146) begin
        assertCount++;
        if (err_stuck !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL stuck_early: got %0b at cycle %0d, required 0", err_stuck, cyc);
        end
      end
      if (cyc == n + 147) begin
        assertCount++;
        if (err_stuck !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL stuck_set: got %0b at cycle %0d, required 1", err_stuck, cyc);
        end
      end
    end
    din = 1'b0;
    repeat (100) step();
    sendPulse(38, 82, 1'b1, 1'b0);
    assertCount++;
    if (err_stuck !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL stuck_sticky: got %0b, required 1", err_stuck);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int unsigned r;
    din = 1'b1;
    repeat (30) step();
    rst = 1'b0;
    #1;
    assertCount++;
    if ({out_strobe, out_sbit_value, out_stream_reset, err_stuck} !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL midreset_flags: got %b, required 0000",
               {out_strobe, out_sbit_value, out_stream_reset, err_stuck});
    end
    assertCount++;
    if (glitch_cnt !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL midreset_glitch_cnt: got %0d, required 0", glitch_cnt);
    end
    din = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    r = cyc;
    e = '{r + 4801, 1'b1, 1'b0};
    sbQ.push_back(e);
    repeat (4850) step();
  endtask

  initial begin
    test_reset();
    test_bit0();
    test_bit_seq();
    test_stream_reset();
    test_glitch();
    test_stuck();
    test_reset_mid();
    assertCount++;
    if (sbQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: %0d expected strobes outstanding, required 0", sbQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
